keypad_matrix_responder: RTL and testbench

Emulates a 4x4 matrix keypad as the responder side of the row-scan interface. It watches the scanned rows, and for one requested key it pulls the matching column low while that key's row is driven.

It is used in board-level benches and in the two-board demo to drive the gamepad input of the game top without a physical keypad. Each accepted press runs a timed sequence of contact closure, hold, release and inter-key gap.

---
 rtl/keypad_matrix_responder.sv | 68 ++++++
 tb/tb_keypad_matrix_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_responder.sv
// keypad_matrix_responder: 4x4 keypad emulator answering a row scan; KEYPAD_BOUNCE_EN adds a contact-bounce phase before each hold
module keypad_matrix_responder #(
  parameter int DW            = 22,
  parameter int HOLD_CYCLES   = 2_500_000,
  parameter int GAP_CYCLES    = 2_500_000,
  parameter int BOUNCE_CYCLES = 50_000,
  parameter int BOUNCE_TOGGLE = 1024
) (
  input  logic       clk_50MHz_i,
  input  logic       rst_async_la_i,
  input  logic [3:0] rows_i,
  input  logic [3:0] key_i,
  input  logic       press_i,
  output logic [3:0] columns_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;
  localparam logic [DW-1:0] HOLD_LAST = DW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_CYCLES - 1);
`ifdef KEYPAD_BOUNCE_EN
  localparam logic [1:0] BOUNCE = 2'd1;
  localparam logic [DW-1:0] BOUNCE_LAST = DW'(BOUNCE_CYCLES - 1);
  localparam int TOG_BIT = $clog2(BOUNCE_TOGGLE);
`endif
  logic [1:0] state, state_n, start;
  logic [DW-1:0] cnt;
  logic [3:0] rows_m, rows_s, key_q;
  logic contact, last;
`ifdef KEYPAD_BOUNCE_EN
  assign start   = BOUNCE;
  assign last    = (state == HOLD && cnt == HOLD_LAST) || (state == GAP && cnt == GAP_LAST) ||
                   (state == BOUNCE && cnt == BOUNCE_LAST);
  // counter bit low means closed, so the bounce starts with the contact made
  assign contact = state == HOLD || (state == BOUNCE && !cnt[TOG_BIT]);
`else
  assign start   = HOLD;
  assign last    = (state == HOLD && cnt == HOLD_LAST) || (state == GAP && cnt == GAP_LAST);
  assign contact = state == HOLD;
`endif
  always_comb begin
    state_n = state == IDLE ? (press_i ? start : IDLE) :
              !last ? state :
              state == HOLD ? GAP :
              state == GAP ? IDLE : HOLD;
  end
  assign busy_o = state != IDLE;
  assign done_o = state == GAP && cnt == GAP_LAST;
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      rows_m    <= 4'hF;
      rows_s    <= 4'hF;
      state     <= IDLE;
      cnt       <= '0;
      key_q     <= 4'h0;
      columns_o <= 4'hF;
    end else begin
      rows_m    <= rows_i;
      rows_s    <= rows_m;
      state     <= state_n;
      cnt       <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
      if (state == IDLE && press_i) key_q <= key_i;
      columns_o <= (contact && !rows_s[key_q[3:2]]) ? ~(4'b0001 << key_q[1:0]) : 4'hF;
    end
  end
endmodule

// File: tb/tb_keypad_matrix_responder.sv
// tb_keypad_matrix_responder: directed and random presses checked each cycle against a timeline model of the keypad
module tb_keypad_matrix_responder;
  localparam int H = 100, G = 50, B = 32, T = 8;
`ifdef KEYPAD_BOUNCE_EN
  localparam int BC = B;
`else
  localparam int BC = 0;
`endif
  localparam int L = BC + H + G;
  logic clk = 0, rst_n = 0, press = 0;
  logic [3:0] rows = 4'hF, key = 4'h0, cols;
  logic busy, done;
  int checks = 0, failures = 0;
  int cyc, acc;
  logic [3:0] kq, r1, r2, exp_cols;
  logic exp_busy, exp_done;

  keypad_matrix_responder #(.DW(22), .HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_CYCLES(B), .BOUNCE_TOGGLE(T)) dut (
    .clk_50MHz_i(clk), .rst_async_la_i(rst_n), .rows_i(rows), .key_i(key), .press_i(press),
    .columns_o(cols), .busy_o(busy), .done_o(done));

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, want);
    end
  endtask

  // phase p counts clocks since the press was accepted (0 = first busy cycle)
  function automatic bit contact_at(int p);
    if (p < 0 || p >= L) return 0;
    if (p < BC) return (p / T) % 2 == 0;
    return p < BC + H;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cyc = 0; acc = -100000; kq = 4'h0; r1 = 4'hF; r2 = 4'hF;
      exp_cols = 4'hF; exp_busy = 0; exp_done = 0;
    end else begin
      cyc++;
      exp_cols = (contact_at(cyc - 1 - acc) && !r2[kq[3:2]]) ? ~(4'b0001 << kq[1:0]) : 4'hF;
      if (press && !(cyc - 1 - acc >= 0 && cyc - 1 - acc < L)) begin
        acc = cyc;
        kq = key;
      end
      exp_busy = cyc - acc >= 0 && cyc - acc < L;
      exp_done = cyc - acc == L - 1;
      r2 = r1;
      r1 = rows;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("cols", cols, exp_cols);
      chk("busy", {3'b0, busy}, {3'b0, exp_busy});
      chk("done", {3'b0, done}, {3'b0, exp_done});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] k);
    @(posedge clk);
    #1 press = 1; key = k;
    @(posedge clk);
    #1 press = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rows = 4'b1110;
    step(3);
    chk("rst_cols", cols, 4'hF);
    chk("rst_busy", {3'b0, busy}, 4'h0);
    chk("rst_done", {3'b0, done}, 4'h0);
    rst_n = 1;
    step(2);
    rows = 4'b1101;
    press_key(4'h6);
    chk("acc_busy", {3'b0, busy}, 4'h1);
    chk("acc_cols", cols, 4'hF);
    step(1 + BC);
    chk("hold_first", cols, 4'b1011);
    step(H - 1);
    chk("hold_last", cols, 4'b1011);
    step(1);
    chk("released", cols, 4'hF);
    step(G - 2);
    chk("done_pulse", {3'b0, done}, 4'h1);
    chk("busy_at_done", {3'b0, busy}, 4'h1);
    step(1);
    chk("idle_busy", {3'b0, busy}, 4'h0);
    chk("idle_done", {3'b0, done}, 4'h0);
`ifdef KEYPAD_BOUNCE_EN
    rows = 4'b1110;
    press_key(4'h0);
    step(1);
    chk("bounce_closed", cols, 4'b1110);
    step(8);
    chk("bounce_open", cols, 4'hF);
    step(8);
    chk("bounce_closed2", cols, 4'b1110);
    step(L);
`endif
    fork
      begin
        press_key(4'h6);
        step(L + 5);
      end
      for (int i = 0; i < (L + 20) / 4; i++) begin
        rows = ~(4'b0001 << (i % 4));
        step(4);
      end
    join
    rows = 4'b1101;
    press_key(4'h6);
    step(20);
    press_key(4'h9);
    for (int i = 0; i < L + 10 && !done; i++) step(1);
    chk("done_seen", {3'b0, done}, 4'h1);
    press = 1; key = 4'h3;
    step(1);
    chk("press_at_done_ignored", {3'b0, busy}, 4'h0);
    key = 4'h5;
    step(1);
    chk("press_after_done", {3'b0, busy}, 4'h1);
    press = 0;
    step(L + 5);
    press_key(4'h6);
    step(BC + H / 2);
    #5 rst_n = 0;
    #1;
    chk("midrst_cols", cols, 4'hF);
    chk("midrst_busy", {3'b0, busy}, 4'h0);
    chk("midrst_done", {3'b0, done}, 4'h0);
    @(posedge clk);
    #1 rst_n = 1;
    step(L);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0)
        rows = $urandom_range(0, 2) == 0 ? 4'($urandom) : ~(4'b0001 << $urandom_range(0, 3));
      press = $urandom_range(0, 39) == 0;
      key = 4'($urandom);
      step(1);
    end
    press = 0;
    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
